// File: rtl/mem_stage_bus_ctrl_if.sv
// Data-bus bundle between the M-stage controller (master) and memory (slave).
// The master drives a held request; the slave answers with ack and read data.
interface mem_stage_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_bus_ctrl.sv
// M-stage load/store controller: issues one bus access per valid MREG instruction,
// stalls the pipeline until ack or timeout, and extends load data for W.
module mem_stage_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        m_valid,
  input  logic [3:0]                  m_op,
  input  logic [31:0]                 m_addr,
  input  logic [31:0]                 m_wdata,
  input  logic [31:0]                 m_pc,
  mem_stage_bus_ctrl_if.master        bus,
  output logic                        stall,
  output logic                        done,
  output logic [31:0]                 ld_data,
  output logic                        bus_err,
  output logic                        exc_adel,
  output logic                        exc_ades,
  output logic [31:0]                 exc_pc
);
  localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                         OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic [3:0]  op_reg;
  logic [1:0]  lane_reg;

  logic        is_load, is_store, is_word, is_half, misaligned, idle, issue, timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, rdata_shift, ld_ext;

  always_comb begin
    is_load    = (m_op >= OP_LW) && (m_op <= OP_LBU);
    is_store   = (m_op >= OP_SW) && (m_op <= OP_SB);
    is_word    = (m_op == OP_LW) || (m_op == OP_SW);
    is_half    = (m_op == OP_LH) || (m_op == OP_LHU) || (m_op == OP_SH);
    misaligned = is_word ? (m_addr[1:0] != 2'b00) : (is_half & m_addr[0]);
    idle       = (state_reg == S_IDLE);
    issue      = idle & m_valid & (is_load | is_store) & ~misaligned;
    exc_adel   = idle & m_valid & is_load & misaligned;
    exc_ades   = idle & m_valid & is_store & misaligned;
    exc_pc     = m_pc;
    stall      = issue | (state_reg == S_REQ);
    timeout    = (cnt_reg == TO_LAST);
  end

  // Lane selection for byte enables and store replication.
  always_comb begin
    if (is_word) begin
      be_next    = 4'b1111;
      wdata_next = m_wdata;
    end else if (is_half) begin
      be_next    = m_addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{m_wdata[15:0]}};
    end else begin
      be_next    = 4'b0001 << m_addr[1:0];
      wdata_next = {4{m_wdata[7:0]}};
    end
    if (!is_store)
      wdata_next = 32'd0;
  end

  // Op and lane are latched at issue so extension does not depend on MREG staying frozen.
  always_comb begin
    rdata_shift = bus.bus_rdata >> {lane_reg, 3'b000};
    case (op_reg)
      OP_LH:   ld_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      OP_LHU:  ld_ext = {16'd0, rdata_shift[15:0]};
      OP_LB:   ld_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      OP_LBU:  ld_ext = {24'd0, rdata_shift[7:0]};
      OP_LW:   ld_ext = bus.bus_rdata;
      default: ld_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (issue) state_next = S_REQ;
      S_REQ:   if (bus.bus_ack || timeout) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
      done          <= 1'b0;
      ld_data       <= 32'd0;
      bus_err       <= 1'b0;
      cnt_reg       <= 8'd0;
      op_reg        <= 4'd0;
      lane_reg      <= 2'd0;
    end else begin
      done <= (state_reg == S_REQ) && (bus.bus_ack || timeout);
      case (state_reg)
        S_IDLE: begin
          if (issue) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= is_store;
            bus.bus_addr  <= {m_addr[31:2], 2'b00};
            bus.bus_be    <= be_next;
            bus.bus_wdata <= wdata_next;
            op_reg        <= m_op;
            lane_reg      <= m_addr[1:0];
            cnt_reg       <= 8'd0;
          end
        end
        S_REQ: begin
          cnt_reg <= cnt_reg + 8'd1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            ld_data     <= ld_ext;
            bus_err     <= 1'b0;
          end else if (timeout) begin
            bus.bus_req <= 1'b0;
            ld_data     <= 32'd0;
            bus_err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_bus_ctrl.sv
// Directed plus randomized bench for mem_stage_bus_ctrl with a short timeout,
// checked against a transaction-level reference model.
module tb_mem_stage_bus_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_wdata, m_pc;
  logic        stall, done, bus_err, exc_adel, exc_ades;
  logic [31:0] ld_data, exc_pc;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_ld;
  logic        exp_err;

  mem_stage_bus_ctrl_if mbus();

  mem_stage_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_pc(m_pc), .bus(mbus), .stall(stall), .done(done),
    .ld_data(ld_data), .bus_err(bus_err), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_bytes(input int op);
    if (op == 1 || op == 6) return 4;
    if (op == 2 || op == 3 || op == 7) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    logic [15:0] h;
    logic [7:0]  b;
    sh = rdata >> (8 * int'(addr % 4));
    h  = sh[15:0];
    b  = sh[7:0];
    case (op)
      1: return rdata;
      2: return 32'($signed(h));
      3: return 32'(h);
      4: return 32'($signed(b));
      5: return 32'(b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic txn(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                     input int ack_at, input logic [31:0] rdata);
    int          n;
    bit          valid_op, is_ld, misal, acked;
    logic [3:0]  e_be;
    logic [31:0] e_wd, pc;
    n        = op_bytes(op);
    valid_op = (op >= 1 && op <= 8);
    is_ld    = (op >= 1 && op <= 5);
    misal    = valid_op && ((addr % n) != 0);
    e_be     = 4'(((1 << n) - 1) << (addr % 4));
    e_wd     = 32'd0;
    if (!is_ld && valid_op)
      for (int i = 0; i < 4 / n; i++)
        e_wd = e_wd | ((wdata & 32'((64'd1 << (8 * n)) - 1)) << (8 * n * i));
    pc       = $urandom;
    m_valid  = 1'b1;
    m_op     = 4'(op);
    m_addr   = addr;
    m_wdata  = wdata;
    m_pc     = pc;
    #1;
    check("exc_pc", exc_pc, pc);
    check("exc_adel", 32'(exc_adel), 32'(misal && is_ld));
    check("exc_ades", 32'(exc_ades), 32'(misal && !is_ld));
    if (!valid_op || misal) begin
      check("stall_noissue", 32'(stall), 32'd0);
      tick();
      check("req_noissue", 32'(mbus.bus_req), 32'd0);
      check("done_noissue", 32'(done), 32'd0);
      check("ld_hold", ld_data, exp_ld);
      $display("txn op=%0d addr=%h no access (adel=%0b ades=%0b)", op, addr, exc_adel, exc_ades);
      return;
    end
    check("stall_issue", 32'(stall), 32'd1);
    tick();
    acked = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      check("req_high", 32'(mbus.bus_req), 32'd1);
      check("bus_we", 32'(mbus.bus_we), 32'(!is_ld));
      check("bus_addr", mbus.bus_addr, addr & 32'hFFFF_FFFC);
      check("bus_be", 32'(mbus.bus_be), 32'(e_be));
      check("bus_wdata", mbus.bus_wdata, e_wd);
      check("stall_req", 32'(stall), 32'd1);
      check("done_req", 32'(done), 32'd0);
      if (k == ack_at) begin
        mbus.bus_ack   = 1'b1;
        mbus.bus_rdata = rdata;
        tick();
        mbus.bus_ack   = 1'b0;
        mbus.bus_rdata = $urandom;
        acked = 1'b1;
        break;
      end
      mbus.bus_rdata = $urandom;
      tick();
    end
    exp_ld  = acked ? model_load(op, addr, rdata) : 32'd0;
    exp_err = !acked;
    check("done_pulse", 32'(done), 32'd1);
    check("req_done", 32'(mbus.bus_req), 32'd0);
    check("stall_done", 32'(stall), 32'd0);
    check("bus_err", 32'(bus_err), 32'(exp_err));
    check("ld_data", ld_data, exp_ld);
    tick();
    m_valid = 1'b0;
    #1;
    check("no_reissue", 32'(mbus.bus_req), 32'd0);
    check("done_once", 32'(done), 32'd0);
    check("stall_after", 32'(stall), 32'd0);
    $display("txn op=%0d addr=%h wdata=%h ack_at=%0d -> ld_data=%h err=%0b", op, addr, wdata, ack_at, ld_data, bus_err);
  endtask

  initial begin
    reset = 1'b1; m_valid = 1'b0; m_op = 4'd0; m_addr = 32'd0; m_wdata = 32'd0; m_pc = 32'd0;
    mbus.bus_ack = 1'b0; mbus.bus_rdata = 32'd0;
    exp_ld = 32'd0; exp_err = 1'b0;
    tick(); tick();
    check("rst_req", 32'(mbus.bus_req), 32'd0);
    check("rst_we", 32'(mbus.bus_we), 32'd0);
    check("rst_addr", mbus.bus_addr, 32'd0);
    check("rst_be", 32'(mbus.bus_be), 32'd0);
    check("rst_wdata", mbus.bus_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ld", ld_data, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    tick();

    txn(1, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF);
    txn(4, 32'h0000_1003, 32'h0, 1, 32'h80FF_0000);
    txn(5, 32'h0000_1003, 32'h0, 2, 32'h80FF_0000);
    txn(2, 32'h0000_1002, 32'h0, 1, 32'h80FF_0000);
    txn(3, 32'h0000_1002, 32'h0, 4, 32'h80FF_0000);
    txn(8, 32'h0000_2001, 32'h1234_56AB, 2, 32'h0);
    txn(7, 32'h0000_2002, 32'h1234_56AB, 1, 32'h0);
    txn(1, 32'h0000_1002, 32'h0, 1, 32'h0);
    txn(7, 32'h0000_1001, 32'h0, 1, 32'h0);
    txn(0, 32'h0000_1000, 32'h0, 1, 32'h0);
    txn(12, 32'h0000_1000, 32'h0, 1, 32'h0);

    // Timeout, then a late ack in IDLE must change nothing.
    txn(1, 32'h0000_4000, 32'h0, 0, 32'h0);
    mbus.bus_ack = 1'b1; mbus.bus_rdata = 32'h5555_AAAA;
    tick();
    check("late_ack_req", 32'(mbus.bus_req), 32'd0);
    check("late_ack_done", 32'(done), 32'd0);
    check("late_ack_err", 32'(bus_err), 32'd1);
    check("late_ack_ld", ld_data, 32'd0);
    mbus.bus_ack = 1'b0;
    $display("txn late ack after timeout ignored check done");

    // Reset during the second REQ cycle.
    m_valid = 1'b1; m_op = 4'd1; m_addr = 32'h0000_3000; m_pc = 32'h0;
    #1;
    check("rstreq_issue", 32'(stall), 32'd1);
    tick();
    tick();
    check("rstreq_req2", 32'(mbus.bus_req), 32'd1);
    reset = 1'b1; m_valid = 1'b0;
    tick();
    check("rstreq_req", 32'(mbus.bus_req), 32'd0);
    check("rstreq_stall", 32'(stall), 32'd0);
    check("rstreq_done", 32'(done), 32'd0);
    reset = 1'b0; exp_ld = 32'd0; exp_err = 1'b0;
    tick();
    check("rstreq_idle_req", 32'(mbus.bus_req), 32'd0);
    check("rstreq_idle_done", 32'(done), 32'd0);
    $display("txn reset during REQ aborted access");
    txn(1, 32'h0000_5008, 32'h0, 2, 32'h0BAD_F00D);
    txn(6, 32'h0000_500C, 32'hCAFE_0001, 1, 32'h0);

    for (int r = 0; r < 40; r++)
      txn($urandom_range(0, 15), $urandom, $urandom, $urandom_range(1, TO + 1), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
